// File: rtl/ptos_link_sequencer_if.sv
// Lane-side handshake and serial output bundle for ptos_link_sequencer.
// The master drives link control and data; the slave is the sequencer.
interface ptos_link_sequencer_if;
   logic       active;
   logic       valid_in;
   logic [7:0] data_in;
   logic       data_rd;
   logic       outs;
   logic       outc;
   logic       sym_start;
   logic [1:0] state;

   modport master (
      output active,
      output valid_in,
      output data_in,
      input  data_rd,
      input  outs,
      input  outc,
      input  sym_start,
      input  state
   );

   modport slave (
      input  active,
      input  valid_in,
      input  data_in,
      output data_rd,
      output outs,
      output outc,
      output sym_start,
      output state
   );
endinterface

// File: rtl/ptos_link_sequencer.sv
// One-lane parallel-to-serial sequencer: COM training burst, then data
// bytes MSB first, with IDLE filling every slot that has no valid byte.
module ptos_link_sequencer #(
   parameter logic [7:0] COM_CHAR  = 8'hBC,
   parameter logic [7:0] IDLE_CHAR = 8'h7C,
   parameter int         COM_COUNT = 4
) (
   input logic                  clk32f,
   input logic                  reset,
   ptos_link_sequencer_if.slave lnk
);

   typedef enum logic [1:0] {
      OFF   = 2'd0,
      TRAIN = 2'd1,
      RUN   = 2'd2
   } state_t;

   localparam logic [3:0] COM_LAST = 4'(COM_COUNT);

   state_t     st;
   logic [2:0] bit_cnt;
   logic [3:0] com_cnt;
   logic [7:0] shreg;
   logic       outc_q;

   logic boundary;
   logic burst_done;
   logic run_load;

   assign boundary   = (bit_cnt == 3'd7);
   assign burst_done = (st == TRAIN) && (com_cnt == COM_LAST);
   assign run_load   = (st == RUN) || burst_done;

   assign lnk.data_rd   = boundary & lnk.active & lnk.valid_in & run_load;
   assign lnk.outs      = shreg[7];
   assign lnk.outc      = outc_q;
   assign lnk.state     = st;
   assign lnk.sym_start = (bit_cnt == 3'd0) && (st != OFF);

   always_ff @(posedge clk32f or negedge reset) begin
      if (!reset) begin
         st      <= OFF;
         bit_cnt <= 3'd0;
         com_cnt <= 4'd0;
         shreg   <= 8'd0;
         outc_q  <= 1'b0;
      end else begin
         bit_cnt <= bit_cnt + 3'd1;
         if (!boundary) begin
            shreg <= {shreg[6:0], 1'b0};
         end else if (!lnk.active) begin
            st      <= OFF;
            shreg   <= 8'd0;
            outc_q  <= 1'b0;
            com_cnt <= 4'd0;
         end else begin
            unique case (1'b1)
               (st == OFF): begin
                  st      <= TRAIN;
                  shreg   <= COM_CHAR;
                  outc_q  <= 1'b1;
                  com_cnt <= 4'd1;
               end
               (st == TRAIN && !burst_done): begin
                  shreg   <= COM_CHAR;
                  outc_q  <= 1'b1;
                  com_cnt <= com_cnt + 4'd1;
               end
               run_load: begin
                  st <= RUN;
                  if (lnk.valid_in) begin
                     shreg  <= lnk.data_in;
                     outc_q <= 1'b0;
                  end else begin
                     shreg  <= IDLE_CHAR;
                     outc_q <= 1'b1;
                  end
               end
               default: begin
                  // unused encoding recovers to OFF
                  st      <= OFF;
                  shreg   <= 8'd0;
                  outc_q  <= 1'b0;
                  com_cnt <= 4'd0;
               end
            endcase
         end
      end
   end

endmodule
